// File: rtl/line_drawer_pkg.sv
// Shared types, widths and helpers for the Bresenham line drawer.
package line_pkg;

   localparam int unsigned X_W      = 10;
   localparam int unsigned Y_W      = 9;
   localparam int unsigned D_W      = 11;
   localparam int unsigned ERR_W    = 12;
   localparam int unsigned E2_W     = 13;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRAW,
      DONE
   } state_t;

   // Magnitude of an endpoint difference plus the direction of travel.
   typedef struct packed {
      logic [D_W-1:0] mag;
      logic           up;
   } diff_t;

   // |b-a| and whether the walk from a to b is increasing (a<b).
   function automatic diff_t abs_diff(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
      diff_t r;
      r.up  = (a < b);
      r.mag = r.up ? (b - a) : (a - b);
      return r;
   endfunction

endpackage

// File: rtl/line_drawer_if.sv
// Endpoint request and pixel stream between the wipe controller and the drawer.
interface line_drawer_if;
   import line_pkg::*;

   logic           start;
   logic [X_W-1:0] x0;
   logic [Y_W-1:0] y0;
   logic [X_W-1:0] x1;
   logic [Y_W-1:0] y1;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           pixel_valid;
   logic           pixel_ready;
   logic           busy;
   logic           done;

   // Controller / frame-buffer side.
   modport master (
      output start, x0, y0, x1, y1, pixel_ready,
      input  x, y, pixel_valid, busy, done
   );

   // Line drawer side.
   modport slave (
      input  start, x0, y0, x1, y1, pixel_ready,
      output x, y, pixel_valid, busy, done
   );

endinterface

// File: rtl/line_drawer.sv
// Integer Bresenham line drawer, all octants, with valid/ready pixel output.
module line_drawer
   import line_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   line_drawer_if.slave bus
);

   state_t                  state_q, state_d;
   logic [X_W-1:0]          x0_q, x0_d, x1_q, x1_d;
   logic [Y_W-1:0]          y0_q, y0_d, y1_q, y1_d;
   logic [D_W-1:0]          dx_q, dx_d;
   logic signed [D_W-1:0]   dy_q, dy_d;
   logic                    sx_q, sx_d, sy_q, sy_d;
   logic signed [ERR_W-1:0] err_q, err_d;
   logic [X_W-1:0]          x_q, x_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic                    pv_q, pv_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   diff_t                   ddx, ddy;
   logic signed [D_W-1:0]   dy_new;
   logic signed [E2_W-1:0]  e2, dx_e2, dy_e2;
   logic                    step_x, step_y, at_end, accept;
   logic signed [ERR_W-1:0] err_step;

   // State and datapath registers, synchronously cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         err_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         pv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         err_q   <= err_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pv_q    <= pv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, setup arithmetic and Bresenham step.
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      err_d   = err_q;
      x_d     = x_q;
      y_d     = y_q;
      pv_d    = 1'b0;

      ddx      = abs_diff(D_W'(x0_q), D_W'(x1_q));
      ddy      = abs_diff(D_W'(y0_q), D_W'(y1_q));
      dy_new   = -$signed(ddy.mag);
      e2       = $signed({err_q, 1'b0});
      dx_e2    = $signed(E2_W'(dx_q));
      dy_e2    = E2_W'(dy_q);
      step_x   = (e2 >= dy_e2);
      step_y   = (e2 <= dx_e2);
      err_step = err_q + (step_x ? ERR_W'(dy_q) : ERR_W'(0))
                       + (step_y ? $signed(ERR_W'(dx_q)) : ERR_W'(0));
      at_end   = (x_q == x1_q) && (y_q == y1_q);
      accept   = pv_q && bus.pixel_ready;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               x0_d    = bus.x0;
               y0_d    = bus.y0;
               x1_d    = bus.x1;
               y1_d    = bus.y1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            dx_d    = ddx.mag;
            dy_d    = dy_new;
            sx_d    = ddx.up;
            sy_d    = ddy.up;
            err_d   = $signed(ERR_W'(ddx.mag)) + ERR_W'(dy_new);
            x_d     = x0_q;
            y_d     = y0_q;
            state_d = DRAW;
         end
         DRAW: begin
            // Pixel is presented from the cycle after DRAW is entered.
            pv_d = 1'b1;
            if (accept) begin
               if (at_end) begin
                  pv_d    = 1'b0;
                  state_d = DONE;
               end else begin
                  err_d = err_step;
                  if (step_x) x_d = sx_q ? (x_q + X_W'(1)) : (x_q - X_W'(1));
                  if (step_y) y_d = sy_q ? (y_q + Y_W'(1)) : (y_q - Y_W'(1));
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SETUP) || (state_d == DRAW);
      done_d = (state_d == DONE);
   end

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.pixel_valid = pv_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_line_drawer.sv
// Scoreboard bench for line_drawer: reference pixel lists vs. accepted pixels.
module tb_line_drawer;
   import line_pkg::*;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pix_t;

   logic clk;
   logic reset;
   line_drawer_if bus();

   line_drawer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   pix_t exp_q[$];
   int   acc_cnt  = 0;
   int   done_cnt = 0;
   int   ready_mode = 0;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Reference: walk the line with plain integer Bresenham, queue every pixel.
   task automatic model(input int ax0, input int ay0, input int ax1, input int ay1, output int n);
      int cx, cy, ddx, ddy, sxi, syi, err, e2;
      cx  = ax0;
      cy  = ay0;
      ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      ddy = (ay1 > ay0) ? -(ay1 - ay0) : -(ay0 - ay1);
      sxi = (ax0 < ax1) ? 1 : -1;
      syi = (ay0 < ay1) ? 1 : -1;
      err = ddx + ddy;
      n   = 0;
      for (int guard = 0; guard < 2000; guard++) begin
         exp_q.push_back(pix_t'{x: X_W'(cx), y: Y_W'(cy)});
         n++;
         if (cx == ax1 && cy == ay1) break;
         e2 = 2 * err;
         if (e2 >= ddy) begin err += ddy; cx += sxi; end
         if (e2 <= ddx) begin err += ddx; cy += syi; end
      end
   endtask

   // Drive pixel_ready each cycle according to the selected pattern.
   initial begin
      bus.pixel_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.pixel_ready = 1'b1;
            1:       bus.pixel_ready = ~bus.pixel_ready;
            default: bus.pixel_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compare accepted pixels, hold-under-stall and done pulses.
   initial begin
      logic           p_valid, p_ready, p_done;
      logic [X_W-1:0] p_x;
      logic [Y_W-1:0] p_y;
      pix_t           e;
      p_valid = 1'b0; p_ready = 1'b0; p_done = 1'b0; p_x = '0; p_y = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (p_valid && !p_ready)
               chk(bus.pixel_valid && bus.x == p_x && bus.y == p_y, "stall_hold",
                   int'({bus.x, bus.y}), int'({p_x, p_y}));
            if (bus.pixel_valid && bus.pixel_ready) begin
               acc_cnt++;
               n_checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL pixel: got (%0d,%0d), required no pixel", bus.x, bus.y);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.x == e.x && bus.y == e.y) n_pass++;
                  else $display("FAIL pixel: got (%0d,%0d), required (%0d,%0d)",
                                bus.x, bus.y, e.x, e.y);
               end
            end
            if (bus.done) begin
               done_cnt++;
               chk(!bus.busy, "done_busy_excl", int'(bus.busy), 0);
               chk(!p_done, "done_single", int'(p_done), 0);
               chk(!bus.pixel_valid, "done_no_valid", int'(bus.pixel_valid), 0);
            end
         end
         p_valid = bus.pixel_valid && !reset;
         p_ready = bus.pixel_ready;
         p_done  = bus.done && !reset;
         p_x     = bus.x;
         p_y     = bus.y;
      end
   end

   task automatic set_start(input int ax0, input int ay0, input int ax1, input int ay1);
      bus.start = 1'b1;
      bus.x0    = X_W'(ax0);
      bus.y0    = Y_W'(ay0);
      bus.x1    = X_W'(ax1);
      bus.y1    = Y_W'(ay1);
   endtask

   task automatic scramble();
      bus.x0 = X_W'($urandom_range(0, SCREEN_W - 1));
      bus.y0 = Y_W'($urandom_range(0, SCREEN_H - 1));
      bus.x1 = X_W'($urandom_range(0, SCREEN_W - 1));
      bus.y1 = Y_W'($urandom_range(0, SCREEN_H - 1));
   endtask

   // Draw one line and check count, latency, single done and drained scoreboard.
   task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                       input int rmode, input bit inject);
      int n, k, first_k, budget, span;
      ready_mode = rmode;
      model(ax0, ay0, ax1, ay1, n);
      span = ((ax1 > ax0) ? ax1 - ax0 : ax0 - ax1);
      if (((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1) > span) span = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
      chk(n == span + 1, "model_count", n, span + 1);
      acc_cnt  = 0;
      done_cnt = 0;
      budget   = 4 * n + 40;
      @(posedge clk); #1;
      set_start(ax0, ay0, ax1, ay1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble();
      k = 0;
      first_k = -1;
      forever begin
         @(negedge clk);
         if (first_k < 0 && bus.pixel_valid) first_k = k;
         if (bus.done) break;
         k++;
         if (inject && k == 4) set_start(1, 2, 9, 9);
         if (inject && k == 5) bus.start = 1'b0;
         if (k > budget) begin
            chk(1'b0, "done_timeout", k, budget);
            break;
         end
      end
      if (rmode == 0) begin
         chk(first_k == 2, "first_latency", first_k, 2);
         chk(k == n + 2, "done_latency", k, n + 2);
      end
      @(negedge clk);
      chk(!bus.busy && !bus.done, "idle_after_done", int'({bus.busy, bus.done}), 0);
      chk(acc_cnt == n, "pixel_count", acc_cnt, n);
      chk(done_cnt == 1, "done_count", done_cnt, 1);
      chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Abandon a long line by reset at its 4th pixel.
   task automatic reset_mid_draw();
      int n, k;
      ready_mode = 0;
      model(0, 0, 639, 0, n);
      acc_cnt  = 0;
      done_cnt = 0;
      @(posedge clk); #1;
      set_start(0, 0, 639, 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      k = 0;
      while (acc_cnt < 4 && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      chk(acc_cnt == 4 && bus.pixel_valid && bus.x == X_W'(3), "reset_point", int'(bus.x), 3);
      reset = 1'b1;
      @(negedge clk);
      chk(bus.x == '0 && bus.y == '0, "rst_mid_xy", int'({bus.x, bus.y}), 0);
      chk(!bus.pixel_valid && !bus.busy && !bus.done, "rst_mid_flags",
          int'({bus.pixel_valid, bus.busy, bus.done}), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      done_cnt = 0;
      repeat (6) @(negedge clk);
      chk(done_cnt == 0 && !bus.busy && !bus.pixel_valid, "rst_no_done",
          done_cnt, 0);
   endtask

   initial begin
      int ax0, ay0, ax1, ay1, bx, by;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(bus.x == '0, "rst_x", int'(bus.x), 0);
      chk(bus.y == '0, "rst_y", int'(bus.y), 0);
      chk(!bus.pixel_valid, "rst_valid", int'(bus.pixel_valid), 0);
      chk(!bus.busy, "rst_busy", int'(bus.busy), 0);
      chk(!bus.done, "rst_done", int'(bus.done), 0);
      @(posedge clk); #1;
      reset = 1'b0;

      draw(0, 0, 639, 0, 0, 1'b0);
      draw(10, 20, 7, 5, 0, 1'b0);
      draw(100, 100, 100, 100, 0, 1'b0);
      draw(0, 0, 3, 3, 1, 1'b0);
      draw(0, 0, 5, 0, 0, 1'b1);
      reset_mid_draw();
      draw(3, 7, 12, 2, 0, 1'b0);
      draw(639, 479, 0, 0, 2, 1'b0);

      for (int i = 0; i < 24; i++) begin
         if (i % 4 == 0) begin
            ax0 = $urandom_range(0, SCREEN_W - 1); ay0 = $urandom_range(0, SCREEN_H - 1);
            ax1 = $urandom_range(0, SCREEN_W - 1); ay1 = $urandom_range(0, SCREEN_H - 1);
         end else begin
            bx  = $urandom_range(0, SCREEN_W - 41); by = $urandom_range(0, SCREEN_H - 41);
            ax0 = bx + $urandom_range(0, 40); ay0 = by + $urandom_range(0, 40);
            ax1 = bx + $urandom_range(0, 40); ay1 = by + $urandom_range(0, 40);
         end
         draw(ax0, ay0, ax1, ay1, $urandom_range(0, 2), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
